worldmap_port_arb: RTL
======================

// Module: worldmap_port_arb
// PURPOSE
//  Arbitrates the world-map BRAM video port between two requesters: the VGA scaler read path
//  (vid_addr stream) and a CPU-side map-edit path (read/modify/write of map cells via GPIO regs).
//  Sits between scale/colorizer and world_map port B in the clk_75 domain. Video wins by default.
//  A starvation counter guarantees CPU forward progress by stealing single video slots.
// PARAMETERS
//  ADDR_W        14    map address width {row[6:0],col[6:0]}
//  DATA_W        2     map cell width
//  MEM_LAT       1     BRAM read latency in cycles, legal 1..4
//  STARVE_LIMIT  1024  CPU-wait cycles before a video slot is stolen; 0 disables stealing
// PORTS
//  clk         in   1       single clock (clk_75 domain)
//  rstn        in   1       asynchronous, active-low reset
//  vid_req     in   1       video wants a read this cycle (tie to video_on)
//  vid_addr    in   ADDR_W  video read address
//  vid_data    out  DATA_W  pixel returned to colorizer
//  vid_valid   out  1       vid_data corresponds to a vid_req issued MEM_LAT+1 cycles earlier
//  vid_stolen  out  1       this vid_valid slot was stolen; vid_data repeats previous pixel
//  cpu_req     in   1       CPU access request, level, held until cpu_ack
//  cpu_we      in   1       1 = write, 0 = read; stable while cpu_req high
//  cpu_addr    in   ADDR_W  CPU address; stable while cpu_req high
//  cpu_wdata   in   DATA_W  CPU write data; stable while cpu_req high
//  cpu_ack     out  1       one-cycle completion pulse
//  cpu_rdata   out  DATA_W  read data, valid with cpu_ack on reads, held until next read ack
//  mem_addr    out  ADDR_W  BRAM address (registered)
//  mem_we      out  1       BRAM write enable (registered, one cycle per CPU write)
//  mem_din     out  DATA_W  BRAM write data (registered)
//  mem_dout    in   DATA_W  BRAM read data, MEM_LAT cycles after mem_addr
// BEHAVIOUR
//  - Reset (rstn low, async): all outputs 0, FSM IDLE, starve_cnt 0, tag pipeline cleared;
//    in-flight reads are discarded, no cpu_ack is generated for them.
//  - Issue stage: decision on cycle N inputs, mem_* registered and driven in cycle N+1.
//    Exactly one requester is granted per cycle; an idle cycle drives mem_we=0, mem_addr held.
//  - Grant rule: cpu_grant = FSM IDLE & cpu_req & (~vid_req | steal);
//    steal = (STARVE_LIMIT!=0) & (starve_cnt==STARVE_LIMIT). Otherwise vid_req granted.
//  - starve_cnt: +1 each cycle cpu_req high, not granted; saturates at STARVE_LIMIT;
//    cleared on cpu_grant or when cpu_req low.
//  - Tag pipeline (depth MEM_LAT+1) carries {vid,cpu_rd,stolen} per issue slot to route mem_dout.
//  - Video: vid_valid = vid_req delayed MEM_LAT+1 cycles, also asserted for stolen slots;
//    stolen slot: vid_stolen=1, vid_data=last delivered pixel (0 after reset).
//  - FSM: IDLE -> ISSUE on cpu_grant; ISSUE -> ACK (write: mem_we pulses in ISSUE cycle) or
//    RD_WAIT (read); RD_WAIT counts MEM_LAT cycles -> ACK, capturing mem_dout into cpu_rdata;
//    ACK pulses cpu_ack one cycle -> IDLE. New request not granted in the ACK cycle.
//  - Write latency: cpu_ack 2 cycles after grant cycle. Read: MEM_LAT+2 cycles after grant.
//  - cpu_req dropped before grant: request abandoned, no ack. Dropped after grant: access
//    completes and cpu_ack still pulses.
//  - vid_req and cpu_req same cycle, starve_cnt < limit: video wins, starve_cnt increments.
//  - Address arithmetic: none; addresses pass through unmodified, no wrap handling required.
// TESTING
//  1 Video only: vid_req=1, vid_addr 0..127 over 128 cycles, mem preloaded addr[1:0] ->
//    vid_data sequence 0,1,2,3,... starting 2 cycles later (MEM_LAT=1), vid_stolen=0 throughout.
//  2 CPU write in blanking: vid_req=0, cpu write addr 0x0123 data 2 -> mem_we=1 once at 0x0123,
//    cpu_ack 2 cycles after req; subsequent CPU read of 0x0123 returns cpu_rdata=2, ack at +3.
//  3 Starvation: STARVE_LIMIT=8, vid_req=1 continuous, cpu read 0x0040 -> grant at wait cycle 8,
//    exactly one vid_stolen slot, vid_data repeats prior pixel, cpu_ack follows 3 cycles later.
//  4 STARVE_LIMIT=0, vid_req held 1000 cycles with cpu_req high -> no cpu_ack, no mem_we; ack
//    arrives 2 cycles (write) after vid_req drops.
//  5 Reset mid-read: assert rstn=0 between grant and ack -> all outputs 0 immediately, no ack
//    after release; next CPU write completes normally.
//  6 MEM_LAT=3 regression of scenarios 1-3 with vid latency 4 and read ack at grant+5.

Source files
------------

// File: rtl/worldmap_port_arb_if.sv
// worldmap_port_arb_if: request, response and BRAM port-B bundle for the world-map port arbiter
//   slave  : arbiter side. It takes the video and CPU requests plus mem_dout, and it drives the
//            responses and mem_addr/mem_we/mem_din.
//   master : requester/memory side. It drives vid_*/cpu_* requests and mem_dout, and it observes
//            the rest.
interface worldmap_port_arb_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 2
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              vid_stolen;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_dout,
    output vid_data, vid_valid, vid_stolen, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_din
  );
  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_dout,
    input  vid_data, vid_valid, vid_stolen, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/worldmap_port_arb.sv
// worldmap_port_arb: arbitrates world-map BRAM port B between the video read stream and CPU edits
//   clk  : clk_75 domain clock
//   rstn : asynchronous active-low reset
//   bus  : worldmap_port_arb_if.slave
//            vid_req/vid_addr -> vid_data/vid_valid/vid_stolen  (latency MEM_LAT+1)
//            cpu_req/we/addr/wdata -> cpu_ack/cpu_rdata         (write +2, read +MEM_LAT+2)
//            mem_addr/mem_we/mem_din -> BRAM, mem_dout <- BRAM  (MEM_LAT read latency)
// Video wins by default. After STARVE_LIMIT waiting cycles, the CPU steals a single video slot.
module worldmap_port_arb #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 2,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 1024
) (
  input logic                 clk,
  input logic                 rstn,
  worldmap_port_arb_if.slave  bus
);
  localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, ACK} state_t;
  state_t            state;
  logic [CW-1:0]     starve_cnt;
  logic [1:0]        lat_cnt;
  logic              is_wr;
  logic [MEM_LAT:0]  t_vid, t_rd, t_st;
  logic [DATA_W-1:0] last_pix;
  logic [ADDR_W-1:0] next_addr;
  logic              steal, cpu_grant, vid_slot, rd_slot;
  assign steal     = (STARVE_LIMIT != 0) && (starve_cnt == LIM);
  assign cpu_grant = (state == IDLE) && bus.cpu_req && (!bus.vid_req || steal);
  assign next_addr = cpu_grant ? bus.cpu_addr : bus.vid_addr;
  // Tag slot whose BRAM data is on mem_dout this cycle.
  assign vid_slot  = t_vid[MEM_LAT] & ~t_st[MEM_LAT];
  assign rd_slot   = t_rd[MEM_LAT];
  // A stolen slot still produces vid_valid and repeats the last real pixel.
  assign bus.vid_valid  = t_vid[MEM_LAT];
  assign bus.vid_stolen = t_vid[MEM_LAT] & t_st[MEM_LAT];
  assign bus.vid_data   = vid_slot ? bus.mem_dout : last_pix;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      lat_cnt       <= '0;
      is_wr         <= 1'b0;
      t_vid         <= '0;
      t_rd          <= '0;
      t_st          <= '0;
      last_pix      <= '0;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_din   <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      if (cpu_grant || bus.vid_req) bus.mem_addr <= next_addr;
      if (cpu_grant) bus.mem_din <= bus.cpu_wdata;
      bus.mem_we <= cpu_grant & bus.cpu_we;
      t_vid <= {t_vid[MEM_LAT-1:0], bus.vid_req};
      t_rd  <= {t_rd[MEM_LAT-1:0], cpu_grant & ~bus.cpu_we};
      t_st  <= {t_st[MEM_LAT-1:0], cpu_grant & bus.vid_req};
      starve_cnt <= (!bus.cpu_req || cpu_grant) ? '0 :
                    (starve_cnt == LIM) ? starve_cnt : starve_cnt + 1'b1;
      if (vid_slot) last_pix <= bus.mem_dout;
      if (rd_slot) bus.cpu_rdata <= bus.mem_dout;
      bus.cpu_ack <= 1'b0;
      case (state)
        IDLE: if (cpu_grant) begin
          state <= ISSUE;
          is_wr <= bus.cpu_we;
        end
        // A write's mem_we is already on the bus in this cycle, so it can be acknowledged next.
        ISSUE: begin
          lat_cnt     <= '0;
          state       <= is_wr ? ACK : RD_WAIT;
          bus.cpu_ack <= is_wr;
        end
        RD_WAIT: if (lat_cnt == LAT_LAST) begin
          state       <= ACK;
          bus.cpu_ack <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
        ACK: state <= IDLE;
      endcase
    end
  end
endmodule
